pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Programmable serial pattern scanner and controller. Accepts a target bit pattern (1..MAXLEN bits), scans a bounded window of a serial input stream, and raises a Mealy match pulse on the completing bit. Counts matches with saturation and reports completion through a start/busy/done handshake. Sits between the serial bit source and the control logic that configures detection and collects results.

## Interface
- MAXLEN, 8, maximum pattern length in bits (≥2)
- CNTW, 8, match counter width
- WINW, 16, window length width
- LENW, $clog2(MAXLEN+1), pattern length field width (derived)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request a scan; sampled only in IDLE
- abort  in  1  cancel an active scan
- pat  in  MAXLEN  target pattern; pat[pat_len-1] is the first bit received, pat[0] the last
- pat_len  in  LENW  pattern length; legal range 1..MAXLEN
- overlap  in  1  1 = overlapping matches allowed
- win_len  in  WINW  number of valid bits to scan; legal range ≥1
- a  in  1  serial data bit
- a_valid  in  1  a is consumed this cycle (SCAN only)
- y  out  1  Mealy match pulse, combinational
- busy  out  1  high in SCAN
- done  out  1  one-cycle completion pulse
- err  out  1  last start carried an illegal configuration
- match_cnt  out  CNTW  matches in last/current scan, saturating

## Operation
- States: IDLE, SCAN, DONE.
- Reset: state IDLE; busy=0, done=0, y=0, err=0, match_cnt=0; history and counters cleared.
- IDLE, start=1:
  - capture pat, pat_len, overlap and win_len
  - clear match_cnt, bit counter and fill counter
  - pat_len=0, pat_len>MAXLEN or win_len=0: err←1, go to DONE
  - otherwise: err←0, go to SCAN
- SCAN, a_valid=1 and abort=0:
  - shift a into history: hist ← {hist[MAXLEN-2:0], a}
  - fill ← min(fill+1, pat_len)
  - bit counter increments
- Match condition: fill ≥ pat_len-1 and {hist, a} low pat_len bits equal pat[pat_len-1:0].
- On match:
  - y=1 in the same cycle
  - match_cnt increments, saturating at 2^CNTW-1
  - overlap=0: fill ← 0, so the next match needs pat_len fresh bits
- Bit counter reaching win_len on the consumed bit: go to DONE. The final bit can still match.
- SCAN, abort=1: go to IDLE next edge. The current bit is not consumed, y=0 and no done pulse. match_cnt holds its partial value.
- DONE: done=1 for exactly one cycle, then IDLE.
- start in SCAN or DONE is ignored.
- match_cnt and err hold until the next accepted start.
- a_valid=0 in SCAN: nothing changes, y=0.
- pat_len=1: every bit equal to pat[0] matches.

## Timing
- Start accepted at edge N; SCAN from cycle N+1. The first bit can be consumed in cycle N+1.
- y is combinational from a, a_valid, abort and registered state; zero latency.
- match_cnt reflects a match one edge after the y cycle.
- Last window bit consumed in cycle M: done=1 and busy=0 in cycle M+1. match_cnt is final in that cycle.
- Illegal config: done=1 and err=1 in cycle N+1; busy never asserts.
- Back-to-back scans: start may be asserted in the cycle after done, in IDLE.
- Reset mid-scan: immediate return to IDLE with all outputs 0.

## Structure
- Shared package pattern_pkg:
  - state_t enum logic [1:0] {IDLE, SCAN, DONE}
  - default parameter constants
- Sub-module pattern_match_window:
  - history shift register, fill counter and length-masked compare
  - inputs: shift, clear, pat, pat_len
  - output: match
- The controller owns the FSM, bit counter, match counter and handshake.

## Test plan
- Pattern "01" (pat_len=2, pat=2'b01), overlap=1, win_len=7, stream 0,1,0,1,1,0,1 → y on bits 2, 4 and 7; match_cnt=3; done one cycle after bit 7; err=0.
- Pattern "11", stream 1,1,1,1, win_len=4 → overlap=1 gives match_cnt=3 (y on bits 2, 3, 4); overlap=0 gives match_cnt=2 (y on bits 2, 4).
- pat_len=0 or pat_len=9 with MAXLEN=8 → done and err in the cycle after start; busy stays 0; match_cnt=0.
- Abort after 3 of win_len=10 bits, with abort and a_valid both high → no y that cycle, no done pulse, IDLE next cycle, match_cnt holds its partial value; a following start is accepted.
- CNTW=2, pattern "1", 6 ones → match_cnt saturates at 3; y pulses on all 6 bits.
- Reset asserted mid-SCAN with a_valid gaps → all outputs 0 immediately; start during SCAN is ignored.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and default sizes for the serial pattern scanner.
// Provides the controller state encoding used by pattern_scan_ctrl.
package pattern_pkg;

    localparam int MAXLEN_D = 8;
    localparam int CNTW_D   = 8;
    localparam int WINW_D   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_match_window.sv
// History shift register, fill counter and length-masked pattern compare.
// Ports: clk, reset, clear, shift, a (incoming bit), overlap, pat, pat_len -> match (comb).
module pattern_match_window #(
    parameter int MAXLEN = 8,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              a,
    input  logic              overlap,
    input  logic [MAXLEN-1:0] pat,
    input  logic [LENW-1:0]   pat_len,
    output logic              match
);

    localparam logic [LENW:0] ONE = (LENW + 1)'(1);

    logic [MAXLEN-2:0] hist;
    logic [LENW-1:0]   fill;
    logic [MAXLEN-1:0] word;
    logic [MAXLEN-1:0] mask;
    logic              filled;

    // The incoming bit completes the candidate word, so one fewer
    // stored bit than pat_len is enough to evaluate a match.
    always_comb begin
        word   = {hist, a};
        mask   = ~({MAXLEN{1'b1}} << pat_len);
        filled = ({1'b0, fill} + ONE) >= {1'b0, pat_len};
        match  = filled && ((word & mask) == (pat & mask));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= word[MAXLEN-2:0];
            if (match && !overlap)
                fill <= '0;
            else if (fill < pat_len)
                fill <= fill + LENW'(1);
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern scanner with start/busy/done handshake.
// Ports: start/abort control, pat/pat_len/overlap/win_len config, a/a_valid stream -> y, busy, done, err, match_cnt.
module pattern_scan_ctrl
    import pattern_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_D,
    parameter int CNTW   = CNTW_D,
    parameter int WINW   = WINW_D,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] pat,
    input  logic [LENW-1:0]   pat_len,
    input  logic              overlap,
    input  logic [WINW-1:0]   win_len,
    input  logic              a,
    input  logic              a_valid,
    output logic              y,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNTW-1:0]   match_cnt
);

    state_t            state;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ov_q;
    logic [WINW-1:0]   win_q;
    logic [WINW-1:0]   bitcnt;

    logic accept;
    logic illegal;
    logic take;
    logic last;
    logic match;

    always_comb begin
        accept  = (state == IDLE) && start;
        illegal = (pat_len == '0) || (pat_len > LENW'(MAXLEN))
                  || (win_len == '0);
        take    = (state == SCAN) && a_valid && !abort;
        last    = bitcnt == (win_q - WINW'(1));
        y       = take && match;
        busy    = state == SCAN;
        done    = state == DONE;
    end

    pattern_match_window #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_win (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .shift   (take),
        .a       (a),
        .overlap (ov_q),
        .pat     (pat_q),
        .pat_len (len_q),
        .match   (match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ov_q      <= 1'b0;
            win_q     <= '0;
            bitcnt    <= '0;
            match_cnt <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q     <= pat;
                        len_q     <= pat_len;
                        ov_q      <= overlap;
                        win_q     <= win_len;
                        bitcnt    <= '0;
                        match_cnt <= '0;
                        err       <= illegal;
                        state     <= illegal ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (a_valid) begin
                        bitcnt <= bitcnt + WINW'(1);
                        if (y && (match_cnt != '1))
                            match_cnt <= match_cnt + CNTW'(1);
                        if (last)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: queue-based reference model
// compared every cycle, plus literal per-scenario expectations.
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  pat;
    logic [3:0]  pat_len;
    logic        overlap;
    logic [15:0] win_len;
    logic        a;
    logic        a_valid;

    logic        y, busy, done, err;
    logic [7:0]  match_cnt;
    logic        y2, busy2, done2, err2;
    logic [1:0]  match_cnt2;

    int checks = 0;
    int errors = 0;

    int ytot = 0;
    int dtot = 0;
    int btot = 0;

    // reference model state
    int   ms = 0;
    logic [7:0] m_pat = '0;
    int   m_len = 0;
    logic m_ov = 1'b0;
    int   m_wl = 0;
    int   m_bits = 0;
    int   m_cnt = 0;
    logic m_err = 1'b0;
    logic fresh[$];

    always #5 clk = ~clk;

    pattern_scan_ctrl #(
        .MAXLEN (8), .CNTW (8), .WINW (16)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .abort (abort),
        .pat (pat), .pat_len (pat_len), .overlap (overlap),
        .win_len (win_len), .a (a), .a_valid (a_valid),
        .y (y), .busy (busy), .done (done), .err (err),
        .match_cnt (match_cnt)
    );

    pattern_scan_ctrl #(
        .MAXLEN (8), .CNTW (2), .WINW (16)
    ) dut2 (
        .clk (clk), .reset (reset), .start (start), .abort (abort),
        .pat (pat), .pat_len (pat_len), .overlap (overlap),
        .win_len (win_len), .a (a), .a_valid (a_valid),
        .y (y2), .busy (busy2), .done (done2), .err (err2),
        .match_cnt (match_cnt2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Would the last m_len fresh bits, ending with b, spell the pattern?
    function automatic logic mmatch(input logic b);
        int   n;
        int   pos;
        logic r;
        logic ok;
        n = fresh.size() + 1;
        if (ms != 1 || m_len < 1 || n < m_len) return 1'b0;
        ok = 1'b1;
        for (int i = 0; i < m_len; i++) begin
            pos = n - m_len + i;
            r = (pos == n - 1) ? b : fresh[pos];
            if (r != m_pat[m_len-1-i]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_reset();
        ms = 0; m_cnt = 0; m_err = 1'b0; m_bits = 0; m_len = 0;
        fresh.delete();
    endtask

    task automatic model_step();
        logic hit;
        case (ms)
            0: if (start) begin
                m_pat = pat; m_len = int'(pat_len); m_ov = overlap;
                m_wl = int'(win_len); m_cnt = 0; m_bits = 0;
                fresh.delete();
                if (pat_len == 0 || pat_len > 8 || win_len == 0) begin
                    m_err = 1'b1; ms = 2;
                end else begin
                    m_err = 1'b0; ms = 1;
                end
            end
            1: if (abort) ms = 0;
               else if (a_valid) begin
                hit = mmatch(a);
                if (hit) m_cnt++;
                fresh.push_back(a);
                if (fresh.size() > 8) void'(fresh.pop_front());
                if (hit && !m_ov) fresh.delete();
                m_bits++;
                if (m_bits == m_wl) ms = 2;
            end
            default: ms = 0;
        endcase
    endtask

    task automatic compare();
        logic ey;
        ey = (ms == 1) && a_valid && !abort && mmatch(a);
        chk("y", int'(y), int'(ey));
        chk("busy", int'(busy), int'(ms == 1));
        chk("done", int'(done), int'(ms == 2));
        chk("err", int'(err), int'(m_err));
        chk("cnt", int'(match_cnt), (m_cnt > 255) ? 255 : m_cnt);
        chk("y2", int'(y2), int'(ey));
        chk("cnt2", int'(match_cnt2), (m_cnt > 3) ? 3 : m_cnt);
        ytot += int'(y);
        dtot += int'(done);
        btot += int'(busy);
    endtask

    // inputs change 1 time unit after posedge; checks at negedge
    task automatic cyc(input logic st, input logic ab,
                       input logic av, input logic b);
        start = st; abort = ab; a_valid = av; a = b;
        @(negedge clk);
        if (reset) model_reset();
        compare();
        if (!reset) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] p, input logic [3:0] l,
                       input logic ov, input logic [15:0] wl,
                       input logic [31:0] seq, input int n);
        pat = p; pat_len = l; overlap = ov; win_len = wl;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, seq[n-1-i]);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int y0, d0, b0;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; a = 1'b0; a_valid = 1'b0;
        pat = '0; pat_len = '0; overlap = 1'b0; win_len = '0;
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // "01", overlap, stream 0101101
        y0 = ytot; d0 = dtot;
        run(8'b01, 4'd2, 1'b1, 16'd7, 32'b0101101, 7);
        chk("t1_cnt", int'(match_cnt), 3);
        chk("t1_y", ytot - y0, 3);
        chk("t1_done", dtot - d0, 1);
        chk("t1_err", int'(err), 0);

        // "11" over 1111, overlap then non-overlap
        y0 = ytot;
        run(8'b11, 4'd2, 1'b1, 16'd4, 32'b1111, 4);
        chk("t2a_cnt", int'(match_cnt), 3);
        chk("t2a_y", ytot - y0, 3);
        y0 = ytot;
        run(8'b11, 4'd2, 1'b0, 16'd4, 32'b1111, 4);
        chk("t2b_cnt", int'(match_cnt), 2);
        chk("t2b_y", ytot - y0, 2);

        // illegal configurations
        b0 = btot; d0 = dtot;
        run(8'b1, 4'd0, 1'b1, 16'd4, 32'b0, 0);
        chk("t3a_err", int'(err), 1);
        chk("t3a_cnt", int'(match_cnt), 0);
        run(8'b1, 4'd9, 1'b1, 16'd4, 32'b0, 0);
        chk("t3b_err", int'(err), 1);
        chk("t3_busy", btot - b0, 0);
        chk("t3_done", dtot - d0, 2);

        // abort after three bits, with a matching bit pending
        pat = 8'b01; pat_len = 4'd2; overlap = 1'b1; win_len = 16'd10;
        y0 = ytot; d0 = dtot;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_cnt", int'(match_cnt), 1);
        chk("t4_y", ytot - y0, 1);
        chk("t4_done", dtot - d0, 0);
        chk("t4_busy", int'(busy), 0);

        // saturation on the 2-bit counter instance
        y0 = ytot;
        run(8'b1, 4'd1, 1'b1, 16'd6, 32'b111111, 6);
        chk("t5_cnt2", int'(match_cnt2), 3);
        chk("t5_cnt", int'(match_cnt), 6);
        chk("t5_y", ytot - y0, 6);

        // gaps, ignored start, then reset mid-scan
        pat = 8'b1; pat_len = 4'd1; overlap = 1'b1; win_len = 16'd20;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_cnt_pre", int'(match_cnt), 2);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_y_rst", int'(y), 0);
        chk("t6_busy_rst", int'(busy), 0);
        chk("t6_cnt_rst", int'(match_cnt), 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        run(8'b101, 4'd3, 1'b0, 16'd6, 32'b101101, 6);
        chk("t7_cnt", int'(match_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
